// File: rtl/generic_bus_resp_pkg.sv
// rtl/generic_bus_resp_pkg.sv - shared types and constants for the generic bus RAM responder
package generic_bus_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  // Returned in place of RAM data when a read misses the mapped window
  localparam word_t BAD_READ_DATA = 32'hBAD1_BAD1;

  // Merge new data into an old word on the enabled byte lanes only
  function automatic word_t apply_byte_en(input word_t old_word, input word_t new_word, input be_t be);
    word_t merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_word_array.sv
// rtl/ram_word_array.sv - single-port word RAM, combinational read, byte-enabled synchronous write
module ram_word_array
  import generic_bus_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  be_t           be,
  input  word_t         wdata,
  output word_t         rdata
);

  // Contents are deliberately left unreset; they are undefined until written
  word_t mem [DEPTH];

  assign rdata = mem[addr];

  // Byte-lane write; untouched lanes keep their old contents
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= apply_byte_en(mem[addr], wdata, be);
  end

endmodule

// File: rtl/generic_bus_ram_responder.sv
// rtl/generic_bus_ram_responder.sv - RAM-backed responder with programmable latency for a cache port
module generic_bus_ram_responder
  import generic_bus_resp_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  resp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  word_t         wdata_q, wdata_d;
  be_t           be_q, be_d;
  logic          wr_q, wr_d;
  logic          in_range_q, in_range_d;
  logic          busy_q, busy_d;
  word_t         rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          req;
  logic          accept;
  logic [31:0]   offset;
  logic          req_in_range;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  word_t         ram_rdata;
  logic          unused_offset_bits;

  assign req    = ren | wen;
  assign accept = (state_q == IDLE) && req;

  // Wrapping subtraction; an address below the base wraps high and is also caught explicitly
  assign offset             = addr - BASE_ADDR;
  assign req_in_range       = (addr >= BASE_ADDR) && ((offset >> (2 + AW)) == 32'd0);
  assign req_idx            = offset[AW+1:2];
  assign unused_offset_bits = ^offset[1:0];

  // The RAM port follows the index being latched so a 1-cycle latency read still sees the new word
  assign ram_idx = accept ? req_idx : idx_q;

  ram_word_array #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk   (CLK),
    .addr  (ram_idx),
    .we    (ram_we),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state, request latching and registered response outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wr_d       = wr_q;
    in_range_d = in_range_q;
    busy_d     = 1'b1;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d      = req_idx;
          wdata_d    = wdata;
          be_d       = byte_en;
          wr_d       = wen;
          in_range_d = req_in_range;
          cnt_d      = CNT_LOAD;
          state_d    = (CNT_LOAD == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          // Initiator gave up: abandon silently
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = RESP;
        end
      end
      RESP: begin
        // Write commits at the edge closing the completion cycle
        ram_we  = wr_q && in_range_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == RESP) begin
      busy_d = 1'b0;
      err_d  = !in_range_d;
      if (!wr_d) rdata_d = in_range_d ? ram_rdata : BAD_READ_DATA;
    end
  end

  // State and output registers; asynchronous reset drops any pending write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      busy_q     <= 1'b1;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wr_q       <= wr_d;
      in_range_q <= in_range_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign busy  = busy_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// tb/tb_generic_bus_ram_responder.sv - directed self-checking bench for generic_bus_ram_responder
module tb_generic_bus_ram_responder;

  logic        CLK;
  logic        RST;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [2:0]  ren_v;
  logic [2:0]  wen_v;
  logic [31:0] rdata_v [3];
  logic [2:0]  busy_v;
  logic [2:0]  err_v;

  int          n_checks;
  int          n_errors;
  logic [31:0] last_rd;
  int          busy_lows;

  // Three instances with latencies 2, 4 and 1 share the address/data inputs
  generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut0 (
    .CLK(CLK), .RST(RST), .addr(addr), .wdata(wdata), .ren(ren_v[0]), .wen(wen_v[0]),
    .byte_en(byte_en), .rdata(rdata_v[0]), .busy(busy_v[0]), .err(err_v[0]));

  generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(4), .BASE_ADDR(32'h0)) u_dut1 (
    .CLK(CLK), .RST(RST), .addr(addr), .wdata(wdata), .ren(ren_v[1]), .wen(wen_v[1]),
    .byte_en(byte_en), .rdata(rdata_v[1]), .busy(busy_v[1]), .err(err_v[1]));

  generic_bus_ram_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut2 (
    .CLK(CLK), .RST(RST), .addr(addr), .wdata(wdata), .ren(ren_v[2]), .wen(wen_v[2]),
    .byte_en(byte_en), .rdata(rdata_v[2]), .busy(busy_v[2]), .err(err_v[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Raise a request at posedge+1, wait for busy=0 (sampled on negedges), then drop it
  task automatic run(input string tag, input int sel, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     input int exp_lat, input logic exp_err);
    int  lat;
    bit  done;
    logic er;
    ren_v[sel] = r;
    wen_v[sel] = w;
    addr       = a;
    wdata      = d;
    byte_en    = b;
    lat        = 0;
    done       = 0;
    er         = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (busy_v[sel] == 1'b0) begin
        done = 1;
        break;
      end
      @(posedge CLK);
      lat++;
    end
    last_rd = rdata_v[sel];
    er      = err_v[sel];
    chk({tag, "_lat"}, lat, exp_lat);
    if (done) chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    @(posedge CLK);
    #1;
    ren_v[sel] = 1'b0;
    wen_v[sel] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST      = 1'b1;
    ren_v    = '0;
    wen_v    = '0;
    addr     = '0;
    wdata    = '0;
    byte_en  = '0;
    last_rd  = '0;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      for (int s = 0; s < 3; s++) begin
        chk("rst_busy", {31'd0, busy_v[s]}, 32'd1);
        chk("rst_err", {31'd0, err_v[s]}, 32'd0);
        chk("rst_rdata", rdata_v[s], 32'd0);
      end
    end
    @(posedge CLK);
    #1;

    // Basic write/read at latency 2
    run("wr10", 0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2, 1'b0);
    run("rd10", 0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 2, 1'b0);
    chk("rd10_data", last_rd, 32'hDEAD_BEEF);

    // Byte lanes, and an all-lanes-off write that must change nothing
    run("wr14a", 0, 1'b0, 1'b1, 32'h14, 32'h1122_3344, 4'hF, 2, 1'b0);
    run("wr14b", 0, 1'b0, 1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, 2, 1'b0);
    run("rd14", 0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 2, 1'b0);
    chk("rd14_data", last_rd, 32'h11BB_33DD);
    run("wr14z", 0, 1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 2, 1'b0);
    run("rd14z", 0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 2, 1'b0);
    chk("rd14z_data", last_rd, 32'h11BB_33DD);

    // Abort at latency 4
    run("wr24", 1, 1'b0, 1'b1, 32'h24, 32'h5555_AAAA, 4'hF, 4, 1'b0);
    run("rd24", 1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 4, 1'b0);
    chk("rd24_data", last_rd, 32'h5555_AAAA);
    ren_v[1] = 1'b1;
    addr     = 32'h20;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1 ren_v[1] = 1'b0;
    busy_lows = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (busy_v[1] == 1'b0) busy_lows++;
      chk("abort_err", {31'd0, err_v[1]}, 32'd0);
    end
    chk("abort_busy_lows", busy_lows, 0);
    @(posedge CLK);
    #1;
    run("wr20rw", 1, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 4, 1'b0);
    chk("wr20rw_rdata_held", last_rd, 32'h5555_AAAA);
    run("rd20", 1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 4, 1'b0);
    chk("rd20_data", last_rd, 32'hCAFE_F00D);

    // Out of range: 0x1000 would alias word 0 without the range check
    run("wr0", 0, 1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 2, 1'b0);
    run("rd_oor", 0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 2, 1'b1);
    chk("rd_oor_data", last_rd, 32'hBAD1_BAD1);
    @(negedge CLK);
    chk("oor_err_pulse", {31'd0, err_v[0]}, 32'd0);
    @(posedge CLK);
    #1;
    run("wr_oor", 0, 1'b0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 2, 1'b1);
    run("rd0", 0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 2, 1'b0);
    chk("rd0_data", last_rd, 32'h0BAD_F00D);

    // Reset during the completion cycle of a write on latency 2
    run("wr30", 0, 1'b0, 1'b1, 32'h30, 32'h0102_0304, 4'hF, 2, 1'b0);
    wen_v[0] = 1'b1;
    addr     = 32'h30;
    wdata    = 32'hFFFF_FFFF;
    byte_en  = 4'hF;
    repeat (3) @(negedge CLK);
    chk("rstresp_pre_busy", {31'd0, busy_v[0]}, 32'd0);
    #1 RST = 1'b1;
    #1;
    chk("rstresp_busy", {31'd0, busy_v[0]}, 32'd1);
    chk("rstresp_rdata", rdata_v[0], 32'd0);
    wen_v[0] = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    run("rd30", 0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 2, 1'b0);
    chk("rd30_data", last_rd, 32'h0102_0304);

    // Reset during WAIT on latency 4
    wen_v[1] = 1'b1;
    addr     = 32'h24;
    wdata    = 32'h0;
    byte_en  = 4'hF;
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("rstwait_busy", {31'd0, busy_v[1]}, 32'd1);
    wen_v[1] = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    run("rd24b", 1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 4, 1'b0);
    chk("rd24b_data", last_rd, 32'h5555_AAAA);

    // Back-to-back reads at latency 1
    run("wr40", 2, 1'b0, 1'b1, 32'h40, 32'h0F0F_0F0F, 4'hF, 1, 1'b0);
    ren_v[2] = 1'b1;
    addr     = 32'h40;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      chk("b2b_busy", {31'd0, busy_v[2]}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 1) chk("b2b_data", rdata_v[2], 32'h0F0F_0F0F);
    end
    @(posedge CLK);
    #1 ren_v[2] = 1'b0;
    @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
